gravity_drop_controller: RTL
============================

GRAVITY_DROP_CONTROLLER -- requirements
Module: gravity_drop_controller

Interface
REQ-001 SHALL have parameter ROWS, default 4, board height (>=2).
REQ-002 SHALL have parameter COLS, default 4, board width (>=2).
REQ-003 SHALL derive CELLS=ROWS*COLS, CW=clog2(COLS) (min 1), RW=clog2(ROWS) (min 1), MW=clog2(CELLS+1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 state  in  2  game state: 00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME.
REQ-007 drop_req  in  1  one-cycle request to drop a token.
REQ-008 column  in  CW  requested column, sampled with drop_req.
REQ-009 gameboard  out  CELLS  occupancy, 1=occupied; cell index = row*COLS+col, row 0 = bottom.
REQ-010 players_cells  out  CELLS  owner per cell, 0=player1, 1=player2; meaningful only where occupied.
REQ-011 next_player  out  1  0=player1, 1=player2.
REQ-012 busy  out  1  high while a drop is in progress.
REQ-013 drop_done  out  1  one-cycle pulse, token placed.
REQ-014 invalid_column  out  1  one-cycle pulse, request rejected.
REQ-015 placed_row  out  RW  row of last placed token; placed_col  out  CW  its column.
REQ-016 move_count  out  MW  tokens on board; board_full  out  1  high when move_count==CELLS.

Function
REQ-017 SHALL implement FSM IDLE, SCAN; registered row pointer scan_row (RW bits), latched column lat_col, latched player lat_player.
REQ-018 In IDLE with state P1_TURN/P2_TURN and drop_req=1: if column<COLS, SHALL latch column, lat_player=(state==P2_TURN), scan_row=0, go SCAN; else SHALL pulse invalid_column next cycle and stay IDLE.
REQ-019 busy SHALL equal (FSM==SCAN).
REQ-020 Each SCAN cycle SHALL examine cell scan_row*COLS+lat_col: if empty, set gameboard bit, write players_cells bit=lat_player, placed_row=scan_row, placed_col=lat_col, move_count+1, next_player=~lat_player, pulse drop_done next cycle, return IDLE.
REQ-021 If occupied and scan_row<ROWS-1, SHALL increment scan_row, stay SCAN.
REQ-022 If occupied and scan_row==ROWS-1 (column full), SHALL pulse invalid_column next cycle, return IDLE, board/next_player/move_count unchanged.
REQ-023 Latency: request in cycle 0 -> drop_done high in cycle r+2 for landing row r; full column -> invalid_column in cycle ROWS+1; out-of-range column -> invalid_column in cycle 1.
REQ-024 drop_req while busy SHALL be ignored (no queueing, no pulse).
REQ-025 drop_done and invalid_column SHALL never be high together and SHALL each last exactly one cycle.
REQ-026 state GAME_INIT or END_GAME SHALL, on the next edge, clear gameboard, players_cells, move_count, placed_row, placed_col, next_player=0, FSM=IDLE, aborting any SCAN without write or pulse; drop_req ignored.
REQ-027 state change between P1_TURN and P2_TURN during SCAN SHALL not affect lat_player.
REQ-028 move_count SHALL saturate at CELLS; board_full combinational from move_count.

Reset
REQ-029 reset=1 SHALL, on the next edge, force FSM=IDLE and all outputs to 0; reset has priority over state and drop_req.
REQ-030 reset asserted mid-SCAN SHALL abort with no write and no pulse.

Verification
REQ-031 Defaults, reset, state=01, drop_req col 2 -> drop_done cycle 2, gameboard bit 2=1, players_cells bit 2=0, placed_row 0, next_player 1, move_count 1.
REQ-032 Col 1 pre-filled rows 0-2, state=10, drop col 1 -> drop_done cycle 5, bit 13 set, players_cells bit 13=1, next_player 0.
REQ-033 Col 3 full (4 tokens), drop col 3 -> invalid_column cycle 5, gameboard unchanged, move_count 4.
REQ-034 COLS=5 (CW=3), column=6 -> invalid_column cycle 1, busy never high.
REQ-035 Drop into empty col 0 of 4 high column pre-filled rows 0-1, state->00 on cycle 2 -> no drop_done, board cleared, next_player 0.
REQ-036 16 alternating valid drops -> move_count 16, board_full 1; 17th drop -> invalid_column.

Source files
------------

// File: rtl/gravity_drop_controller.sv
// Connect-four style token drop controller: finds the lowest empty cell of a
// column by scanning upward one row per cycle, then records owner and position.
module gravity_drop_controller #(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  localparam int CELLS = ROWS * COLS,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int MW    = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state,
  input  logic             drop_req,
  input  logic [CW-1:0]    column,
  output logic [CELLS-1:0] gameboard,
  output logic [CELLS-1:0] players_cells,
  output logic             next_player,
  output logic             busy,
  output logic             drop_done,
  output logic             invalid_column,
  output logic [RW-1:0]    placed_row,
  output logic [CW-1:0]    placed_col,
  output logic [MW-1:0]    move_count,
  output logic             board_full
);

  localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  localparam logic [1:0] GS_INIT = 2'b00;
  localparam logic [1:0] GS_P1   = 2'b01;
  localparam logic [1:0] GS_P2   = 2'b10;
  localparam logic [1:0] GS_END  = 2'b11;

  logic [0:0]    fsm;
  logic [RW-1:0] scan_row;
  logic [CW-1:0] lat_col;
  logic          lat_player;

  logic          playing;
  logic          col_in_range;
  logic [IW-1:0] cell_idx;
  logic          cell_occupied;
  logic          last_row;

  // Only the two turn states let the controller run; INIT and END wipe the game.
  assign playing = (state == GS_P1) || (state == GS_P2);

  // A power-of-two width cannot encode an out-of-range column.
  generate
    if (COLS == (1 << CW)) begin : g_col_pow2
      assign col_in_range = 1'b1;
    end else begin : g_col_cmp
      assign col_in_range = ({1'b0, column} < (CW + 1)'(COLS));
    end
  endgenerate

  assign cell_idx      = IW'(scan_row) * IW'(COLS) + IW'(lat_col);
  assign cell_occupied = gameboard[cell_idx];
  assign last_row      = (scan_row == RW'(ROWS - 1));

  assign busy       = (fsm == S_SCAN);
  assign board_full = (move_count == MW'(CELLS));

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values; a blocking write would leak into later reads in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the board is a plain flop vector, not a RAM, so clearing it in
      // reset is legal and required; a true memory could not be reset this way.
      fsm            <= S_IDLE;
      scan_row       <= '0;
      lat_col        <= '0;
      lat_player     <= 1'b0;
      gameboard      <= '0;
      players_cells  <= '0;
      next_player    <= 1'b0;
      drop_done      <= 1'b0;
      invalid_column <= 1'b0;
      placed_row     <= '0;
      placed_col     <= '0;
      move_count     <= '0;
    end else begin
      drop_done      <= 1'b0;
      invalid_column <= 1'b0;

      if (!playing) begin
        // Game (re)start or end: abandon any scan without writing or pulsing.
        fsm           <= S_IDLE;
        scan_row      <= '0;
        gameboard     <= '0;
        players_cells <= '0;
        next_player   <= 1'b0;
        placed_row    <= '0;
        placed_col    <= '0;
        move_count    <= '0;
      end else begin
        case (fsm)
          S_IDLE: begin
            if (drop_req) begin
              if (col_in_range) begin
                lat_col    <= column;
                lat_player <= (state == GS_P2);
                scan_row   <= '0;
                fsm        <= S_SCAN;
              end else begin
                invalid_column <= 1'b1;
              end
            end
          end

          S_SCAN: begin
            if (!cell_occupied) begin
              gameboard[cell_idx]     <= 1'b1;
              players_cells[cell_idx] <= lat_player;
              placed_row              <= scan_row;
              placed_col              <= lat_col;
              next_player             <= ~lat_player;
              drop_done               <= 1'b1;
              fsm                     <= S_IDLE;
              if (!board_full) begin
                move_count <= move_count + 1'b1;
              end
            end else if (!last_row) begin
              scan_row <= scan_row + 1'b1;
            end else begin
              invalid_column <= 1'b1;
              fsm            <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Design invariants: exclusive pulses, and the counter tracks the board exactly.
  assert property (@(posedge clk) disable iff (reset) !(drop_done && invalid_column));
  assert property (@(posedge clk) disable iff (reset)
                   move_count == MW'($countones(gameboard)));

endmodule
